cla_pipe_addsub: RTL
====================

Name: cla_pipe_addsub

Overview:
- Parametrised pipelined carry-lookahead adder/subtractor; the next generation of the team's 8-bit combinational CLA.
- Generalised in width, lookahead group size and pipeline depth.
- Adds add/sub/carry-chain modes, status flags and a valid/ready handshake on both sides with full backpressure.
- Sits between an operand source and a result consumer; sustains one operation per cycle.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of GROUP; legal 8..64
GROUP, 4, bits per lookahead group (group P/G generated inside each group; group carries by lookahead across groups)
STAGES, 2, pipeline register stages from accept to result; legal 1..WIDTH/GROUP

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_cin  input  1  carry/borrow-in, used only by ADC/SBC
in_op  input  2  00 ADD, 01 ADC, 10 SUB, 11 SBC
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts result this cycle
out_sum  output  WIDTH  result
out_cout  output  1  carry-out (for SUB/SBC: 1 = no borrow)
out_ovf  output  1  signed two's-complement overflow
out_zero  output  1  out_sum == 0
out_neg  output  1  out_sum[WIDTH-1]

Behaviour:
- Arithmetic, modulo 2^WIDTH; cout is bit WIDTH of the full sum:
  - ADD = a+b+0
  - ADC = a+b+cin
  - SUB = a+~b+1
  - SBC = a+~b+cin
- out_ovf = (opA[MSB] == opB'[MSB]) && (sum[MSB] != opA[MSB]), where opB' is b for ADD/ADC and ~b for SUB/SBC.
- Carries: generated per GROUP with P = a^b', G = a&b'; group carry via lookahead. No full-width ripple chain.
- Each pipeline stage processes a contiguous slice of groups. Inter-stage registers carry the partial sum, the pending carry, and the unprocessed operand slices.
- Accept: a beat is accepted when in_valid && in_ready on a rising edge.
- Latency: the result appears with out_valid=1 exactly STAGES cycles after acceptance when out_ready is held high.
- Throughput: 1 beat/cycle while out_ready=1.
- Pipeline control: each stage has a valid bit.
  - Stage k loads when its valid bit is 0, or when stage k+1 (or the output, for the last stage) is taking its content that cycle.
  - in_ready = !valid_0 || stage 0 advancing. in_ready is combinational from out_ready and the valid bits; there is no in_valid -> in_ready path.
- Output hold: while out_valid && !out_ready, out_sum, out_cout, out_ovf, out_zero and out_neg are stable and the pipeline stalls.
- Capacity: up to STAGES beats in flight. With out_ready low, in_ready deasserts only once all stages are valid.
- Order: results are in strict acceptance order; no drop, no duplication.
- Simultaneous events: in the same cycle, a full pipeline with out_ready=1 accepts a new beat and retires one result.
- Reset (rst=1 at an edge, including mid-operation):
  - All valid bits clear; in-flight beats are discarded.
  - out_valid=0; out_sum=0; out_cout, out_ovf, out_zero and out_neg = 0.
  - in_ready=1 from the first cycle after the reset edge.
  - Inputs are ignored while rst=1.
- Data path registers outside valid stages may hold stale data. Outputs must reflect only the last stage register.
- in_cin is ignored for ADD/SUB.

Test Plan:
- Reset (WIDTH=16, GROUP=4, STAGES=2): assert rst 2 cycles with in_valid=1 -> out_valid=0, out_sum=0x0000, all flags 0, in_ready=1 after release; no result ever emerges from the ignored inputs.
- Carry through all groups: ADD a=0xFFFF b=0x0001, out_ready=1 -> 2 cycles later out_sum=0x0000, cout=1, zero=1, ovf=0, neg=0.
- Subtract/overflow: SUB a=0x8000 b=0x0001 -> 0x7FFF, cout=1, ovf=1, neg=0. SBC a=0x0000 b=0x0000 cin=0 -> 0xFFFF, cout=0, neg=1, ovf=0.
- ADC signed overflow: ADC a=0x7FFF b=0x0000 cin=1 -> 0x8000, ovf=1, neg=1, cout=0. Same beat as ADD -> 0x7FFF (cin ignored).
- Backpressure: issue 6 back-to-back ADDs (a=i, b=0x0100, i=1..6) with out_ready low cycles 2-5 -> in_ready drops once 2 beats are held; out_sum stable while stalled; results 0x0101..0x0106 in order, none lost or repeated; 1 beat/cycle after release.
- Reset mid-flight: accept 2 beats, assert rst on the next edge -> out_valid=0, no stale result after release; a fresh ADD 0x1234+0x1111 yields 0x2345 two cycles after acceptance. Repeat the directed vectors at WIDTH=32, GROUP=8, STAGES=4 against a reference model, with random stalls.

Source files
------------

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor (ADD/ADC/SUB/SBC) with status flags
// and valid/ready handshakes on both sides; each stage resolves a slice of groups.
module cla_pipe_addsub #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned GROUP  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);
    localparam int unsigned NG   = WIDTH / GROUP;
    localparam int unsigned LAST = STAGES - 1;

    // Carry out of the low n positions in two-level form: every generate ANDed with
    // all propagates above it, plus cin ANDed with all n propagates.
    function automatic logic carry_la(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] g,
                                      input logic cin, input int unsigned n);
        logic res;
        logic term;
        logic all_p;
        res   = 1'b0;
        all_p = cin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i < n) begin
                term = g[i];
                for (int unsigned j = 0; j < WIDTH; j++) begin
                    if (j > i && j < n) term = term & p[j];
                end
                res   = res | term;
                all_p = all_p & p[i];
            end
        end
        return res | all_p;
    endfunction

    // Resolve groups [lo, hi) on top of the partial sum; returns {carry_out, sum}.
    function automatic logic [WIDTH:0] slice_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] s_in,
                                                 input logic c_in,
                                                 input int unsigned lo,
                                                 input int unsigned hi);
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] pb;
        logic [WIDTH-1:0] gb;
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] gp;
        logic [WIDTH-1:0] gg;
        logic             cg;
        p  = a ^ b;
        g  = a & b;
        s  = s_in;
        gp = '0;
        gg = '0;
        for (int unsigned k = 0; k < NG; k++) begin
            pb    = p >> (k * GROUP);
            gb    = g >> (k * GROUP);
            gp[k] = carry_la(pb, '0, 1'b1, GROUP);
            gg[k] = carry_la(pb, gb, 1'b0, GROUP);
        end
        gp = gp >> lo;
        gg = gg >> lo;
        for (int unsigned k = 0; k < NG; k++) begin
            if (k >= lo && k < hi) begin
                cg = carry_la(gp, gg, c_in, k - lo);
                pb = p >> (k * GROUP);
                gb = g >> (k * GROUP);
                for (int unsigned i = 0; i < GROUP; i++) begin
                    s[k * GROUP + i] = pb[i] ^ carry_la(pb, gb, cg, i);
                end
            end
        end
        return {carry_la(gp, gg, c_in, hi - lo), s};
    endfunction

    logic [STAGES-1:0] st_v;
    logic [STAGES-1:0] st_c;
    logic [WIDTH-1:0]  st_a [STAGES];
    logic [WIDTH-1:0]  st_b [STAGES];
    logic [WIDTH-1:0]  st_s [STAGES];
    logic              ovf_q;
    logic              zero_q;
    logic              neg_q;

    logic [STAGES-1:0] load;
    logic [STAGES-1:0] nx_v;
    logic [STAGES-1:0] nx_c;
    logic [WIDTH-1:0]  nx_a [STAGES];
    logic [WIDTH-1:0]  nx_b [STAGES];
    logic [WIDTH-1:0]  nx_s [STAGES];
    logic              nx_ovf;
    logic              nx_zero;
    logic              nx_neg;

    // Stage load enables (backpressure chain) and per-stage slice arithmetic.
    always_comb begin
        logic             take;
        logic [WIDTH:0]   r;
        logic             c0;
        load = '0;
        nx_v = '0;
        nx_c = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            nx_a[k] = '0;
            nx_b[k] = '0;
            nx_s[k] = '0;
        end

        take = out_ready;
        for (int k = int'(LAST); k >= 0; k--) begin
            load[k] = !st_v[k] || take;
            take    = load[k];
        end

        c0      = in_op[0] ? in_cin : in_op[1];
        nx_v[0] = in_valid;
        nx_a[0] = in_a;
        nx_b[0] = in_op[1] ? ~in_b : in_b;
        r       = slice_add(nx_a[0], nx_b[0], '0, c0, 0, NG / STAGES);
        nx_s[0] = r[WIDTH-1:0];
        nx_c[0] = r[WIDTH];
        for (int unsigned k = 1; k < STAGES; k++) begin
            nx_v[k] = st_v[k-1];
            nx_a[k] = st_a[k-1];
            nx_b[k] = st_b[k-1];
            r       = slice_add(st_a[k-1], st_b[k-1], st_s[k-1], st_c[k-1],
                                (k * NG) / STAGES, ((k + 1) * NG) / STAGES);
            nx_s[k] = r[WIDTH-1:0];
            nx_c[k] = r[WIDTH];
        end

        nx_ovf  = (nx_a[LAST][WIDTH-1] == nx_b[LAST][WIDTH-1]) &&
                  (nx_s[LAST][WIDTH-1] != nx_a[LAST][WIDTH-1]);
        nx_zero = ~|nx_s[LAST];
        nx_neg  = nx_s[LAST][WIDTH-1];
    end

    // Pipeline registers; data only moves with a valid beat so stalls hold outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_v   <= '0;
            st_c   <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                st_a[k] <= '0;
                st_b[k] <= '0;
                st_s[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    st_v[k] <= nx_v[k];
                    if (nx_v[k]) begin
                        st_a[k] <= nx_a[k];
                        st_b[k] <= nx_b[k];
                        st_s[k] <= nx_s[k];
                        st_c[k] <= nx_c[k];
                    end
                end
            end
            if (load[LAST] && nx_v[LAST]) begin
                ovf_q  <= nx_ovf;
                zero_q <= nx_zero;
                neg_q  <= nx_neg;
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = st_v[LAST];
    assign out_sum   = st_s[LAST];
    assign out_cout  = st_c[LAST];
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;
    assign out_neg   = neg_q;

endmodule
